// File: rtl/led_seq_pkg.sv
// Shared mode codes, FSM state encoding and mode-entry helper for the LED
// blink sequencer.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    localparam int GAP_TICKS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEADY = 3'd1,
        ST_BLINK  = 3'd2,
        ST_B_ON   = 3'd3,
        ST_B_OFF  = 3'd4,
        ST_GAP    = 3'd5
    } led_state_t;

    typedef struct packed {
        led_state_t state;
        logic       led;
    } fsm_entry_t;

    // Entry state and LED level for a mode; BURST with zero blinks parks dark.
    function automatic fsm_entry_t mode_entry(input logic [1:0] mode, input logic burst_nz);
        fsm_entry_t e;
        e.state = ST_IDLE;
        e.led   = 1'b0;
        case (mode)
            MODE_ON:    begin e.state = ST_STEADY; e.led = 1'b1; end
            MODE_BLINK: begin e.state = ST_BLINK;  e.led = 1'b1; end
            MODE_BURST: if (burst_nz) begin e.state = ST_B_ON; e.led = 1'b1; end
            default:    ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Single-clock prescaler: one-cycle registered tick every max(div,1) clocks.
module tick_prescaler #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_restart,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [CNT_W-1:0] w_last;

    // 0 and 1 both give a terminal count of 0, i.e. a tick every cycle.
    assign w_last = (i_div == '0) ? '0 : i_div - CNT_W'(1);
    assign o_tick = r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_restart) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt >= w_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// LED pattern controller: OFF/ON/BLINK/BURST driven by a prescaled tick, with a
// valid/ready config port whose settings take effect on the next tick.
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 50000000,
    parameter int BURST_W     = 4,
    parameter int GAP_TICKS   = GAP_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [1:0]         i_cfg_mode,
    input  logic [CNT_W-1:0]   i_cfg_div,
    input  logic [BURST_W-1:0] i_cfg_burst,
    output logic               o_led,
    output logic               o_tick,
    output logic               o_busy
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_div;
    logic [BURST_W-1:0] r_burst;
    logic [1:0]         r_sh_mode;
    logic [CNT_W-1:0]   r_sh_div;
    logic [BURST_W-1:0] r_sh_burst;
    logic               r_busy;
    logic               r_cfg_ready;

    led_state_t         r_state;
    logic               r_led;
    logic [BURST_W-1:0] r_left;
    logic [GAP_W-1:0]   r_gap;

    logic               w_tick;
    logic               w_xfer;
    logic               w_apply;
    fsm_entry_t         w_apply_entry;
    fsm_entry_t         w_recover_entry;

    assign w_xfer          = i_cfg_valid && r_cfg_ready;
    assign w_apply         = r_busy && w_tick;
    assign w_apply_entry   = mode_entry(r_sh_mode, |r_sh_burst);
    assign w_recover_entry = mode_entry(r_mode, |r_burst);

    assign o_cfg_ready = r_cfg_ready;
    assign o_busy      = r_busy;
    assign o_led       = r_led;
    assign o_tick      = w_tick;

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .i_div     (r_div),
        .i_restart (w_apply),
        .o_tick    (w_tick)
    );

    // Apply needs busy already set, so a transfer can never coincide with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_OFF;
            r_div       <= CNT_W'(DEFAULT_DIV);
            r_burst     <= BURST_W'(1);
            r_sh_mode   <= MODE_OFF;
            r_sh_div    <= '0;
            r_sh_burst  <= '0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else if (w_apply) begin
            r_mode      <= r_sh_mode;
            r_div       <= r_sh_div;
            r_burst     <= r_sh_burst;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else if (w_xfer) begin
            r_sh_mode   <= i_cfg_mode;
            r_sh_div    <= i_cfg_div;
            r_sh_burst  <= i_cfg_burst;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_left  <= '0;
            r_gap   <= '0;
        end else if (w_apply) begin
            r_state <= w_apply_entry.state;
            r_led   <= w_apply_entry.led;
            r_left  <= r_sh_burst;
            r_gap   <= '0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE:   r_led <= 1'b0;
                ST_STEADY: r_led <= 1'b1;
                ST_BLINK:  r_led <= ~r_led;
                ST_B_ON: begin
                    r_state <= ST_B_OFF;
                    r_led   <= 1'b0;
                end
                ST_B_OFF: begin
                    if (r_left > BURST_W'(1)) begin
                        r_state <= ST_B_ON;
                        r_left  <= r_left - BURST_W'(1);
                        r_led   <= 1'b1;
                    end else begin
                        r_state <= ST_GAP;
                        r_gap   <= GAP_W'(GAP_TICKS);
                        r_led   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_state <= ST_B_ON;
                        r_left  <= r_burst;
                        r_led   <= 1'b1;
                    end else begin
                        r_gap   <= r_gap - GAP_W'(1);
                        r_led   <= 1'b0;
                    end
                end
                // Unused encodings fall back to the current mode's entry state.
                default: begin
                    r_state <= w_recover_entry.state;
                    r_led   <= w_recover_entry.led;
                    r_left  <= r_burst;
                    r_gap   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Fully synchronous LED pattern controller that replaces ripple-clocked LED dividers.
- A single-clock prescaler produces a one-cycle tick enable.
- A small FSM drives the LED in OFF, ON, BLINK or BURST mode.
- Host logic reconfigures mode, rate and burst length through a valid/ready handshake; the new configuration takes effect on the next tick boundary.

Parameters:
- CNT_W, 27: prescaler counter width.
- DEFAULT_DIV, 50000000: divide ratio loaded at reset. Must be < 2^CNT_W.
- BURST_W, 4: width of the burst-count field.
- GAP_TICKS, 4: number of ticks the LED stays dark between bursts. Must be ≥ 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- cfg_valid, input, 1: configuration offer.
- cfg_ready, output, 1: configuration accepted when cfg_valid && cfg_ready.
- cfg_mode, input, 2: 0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_div, input, CNT_W: clocks per tick. Values 0 and 1 both mean a tick every cycle.
- cfg_burst, input, BURST_W: blinks per burst in BURST mode.
- led, output, 1: registered LED drive.
- tick, output, 1: registered one-cycle pulse, once per div_q clocks.
- busy, output, 1: a configuration is accepted but not yet applied.

Behaviour:
- **Reset values:**
  - mode_q=OFF, div_q=DEFAULT_DIV, burst_q=1, cnt=0.
  - led=0, tick=0, cfg_ready=1, busy=0.
  - FSM state=IDLE; pending shadow cleared.
  - Reset mid-pattern aborts the pattern immediately; no pending config survives.
- **Prescaler:**
  - cnt counts 0..div_eff-1, where div_eff = max(div_q,1).
  - When cnt==div_eff-1: cnt wraps to 0, and tick is high the following cycle.
  - First tick after reset or after an apply arrives exactly div_eff cycles after that event.
  - Counter arithmetic is unsigned CNT_W; the counter never exceeds div_eff-1.
- **Handshake:**
  - A transfer occurs when cfg_valid && cfg_ready. Inputs are captured into a shadow register.
  - Next cycle: cfg_ready=0, busy=1.
  - While busy, cfg_ready stays 0 and further offers wait.
- **Apply:**
  - Occurs at the first tick cycle after busy rises. A transfer in the same cycle as a tick applies at the following tick, not that one.
  - On apply: mode_q, div_q and burst_q load from the shadow; cnt=0; FSM restarts at its mode entry state.
  - busy drops and cfg_ready rises on the cycle after apply.
- **LED timing:** led is updated only on tick cycles, or on apply. The new value is visible the cycle after.
- **FSM states:** IDLE, STEADY, BLINK, B_ON, B_OFF, GAP.
  - OFF → IDLE: led=0.
  - ON → STEADY: led=1.
  - BLINK → BLINK: led=1 on entry, toggles every tick.
  - BURST with burst_q≥1 → B_ON: led=1, left=burst_q.
    - B_ON → B_OFF on tick, led=0.
    - B_OFF on tick: if left>1, go to B_ON with left-1 and led=1; else go to GAP with gap=GAP_TICKS.
    - GAP: decrements on each tick. Leaving GAP (gap==1 on tick) goes to B_ON with left=burst_q and led=1.
  - BURST with burst_q=0 → IDLE: led=0.
- **Burst timing:** one burst period = 2·burst_q + GAP_TICKS ticks.

Decomposition:
- **Package led_seq_pkg:**
  - Mode constants: MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST.
  - FSM state encoding (3-bit).
  - Default GAP_TICKS.
- **Sub-module tick_prescaler:**
  - Ports: clk, rst, div (CNT_W), restart, tick.
  - Owns cnt and the registered tick.
  - restart clears cnt to 0 on apply.

Test Plan:
- **Reset:** DEFAULT_DIV=4; deassert rst → led=0, cfg_ready=1, busy=0; tick pulses at cycles 4, 8, 12 after reset release.
- **BLINK:** cfg mode=2, div=3 → busy=1 until the next tick. After apply, first tick 3 cycles later and led toggles every 3 clocks: 1,0,1,0.
- **BURST:** mode=3, div=1, burst=2, GAP_TICKS=4 → led per tick: 1,0,1,0,0,0,0,0,1,0… with an 8-tick period.
- **Boundaries:**
  - div=0 behaves the same as div=1 (tick every cycle).
  - burst=0 in BURST mode → led stuck 0.
  - div=2^CNT_W-1 with a short simulation → cnt never wraps early.
- **Back-pressure:**
  - Second cfg_valid held while busy → cfg_ready=0 until the cycle after apply, then accepted.
  - A transfer coincident with a tick applies one tick later.
- **Reset mid-burst:** assert rst during B_ON with busy=1 → led=0, busy=0, cfg_ready=1, and mode OFF on release.
